pic_init_arbiter: RTL and testbench
===================================

Name: pic_init_arbiter

Overview:
- Boot-time configurator for the cascaded master/slave 8259 pair.
- After reset, or on request, it issues the fixed ICW1–ICW4 and OCW1 write sequence to both controllers, so the PC/AT vector map is valid before software runs.
- It owns the PIC I/O port while sequencing and stalls CPU accesses; when idle it passes CPU accesses through.
- While sequencing, it hides the PIC interrupt request from the CPU.

Parameters:
- MASTER_BASE, 8'h08: master ICW2 vector base; bits [2:0] are ignored.
- SLAVE_BASE, 8'h70: slave ICW2 vector base; bits [2:0] are ignored.
- MASTER_MASK, 8'hB8: master OCW1 (IMR) value written last.
- SLAVE_MASK, 8'hFF: slave OCW1 (IMR) value written last.
- WRITE_GAP, 2: idle cycles after each issued write; range 0..15.
- AUTO_INIT, 1: 1 = start the sequence automatically after reset release.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  one-cycle request to re-run the sequence
- init_busy  out  1  sequence in progress
- init_done  out  1  one-cycle pulse when the last write is issued
- cpu_address  in  1  CPU port address bit (A0)
- cpu_read  in  1  CPU read strobe
- cpu_write  in  1  CPU write strobe
- cpu_writedata  in  8  CPU write data
- cpu_master_cs  in  1  CPU select, ports 20h/21h
- cpu_slave_cs  in  1  CPU select, ports A0h/A1h
- cpu_wait  out  1  CPU access stalled; CPU holds its strobes while high
- pic_address  out  1  to PIC io_address
- pic_read  out  1  to PIC io_read
- pic_write  out  1  to PIC io_write
- pic_writedata  out  8  to PIC io_writedata
- pic_master_cs  out  1  to PIC io_master_cs
- pic_slave_cs  out  1  to PIC io_slave_cs
- pic_interrupt_do  in  1  from PIC interrupt_do
- cpu_interrupt_do  out  1  gated interrupt request to the CPU

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n; every flop clears immediately on rst_n low.
- Output reset values: init_busy 0, init_done 0, cpu_wait 0, and all pic_* outputs follow the CPU mux in IDLE.
- States:
  - BOOT: one cycle after reset release. Goes to ISSUE when AUTO_INIT=1, else to IDLE.
  - IDLE: CPU owns the port. init_start goes to ISSUE on the next clk.
  - ISSUE: one-cycle write of step[3:0]. Goes to GAP, or directly to the next ISSUE when WRITE_GAP=0. After step 9, goes to IDLE.
  - GAP: gap_cnt counts WRITE_GAP-1 down to 0, then returns to ISSUE with step+1.
- Write sequence, as address/data/cs:
  - step 0: A0=0, 8'h11, master
  - step 1: A0=1, {MASTER_BASE[7:3],3'b0}, master
  - step 2: A0=1, 8'h04, master
  - step 3: A0=1, 8'h01, master
  - step 4: A0=1, MASTER_MASK, master
  - steps 5–9: the same five writes to the slave, using SLAVE_BASE, 8'h02 (ICW3) and SLAVE_MASK.
- Port ownership while init_busy=1:
  - pic_read=0, and pic_write=1 only in ISSUE.
  - Exactly one of pic_master_cs/pic_slave_cs is high, and only in ISSUE.
- Pass-through when idle: in IDLE (and BOOT with AUTO_INIT=0), pic_* equal cpu_* combinationally and cpu_wait=0.
- Stall rule: while init_busy=1, cpu_wait = (cpu_read|cpu_write) & (cpu_master_cs|cpu_slave_cs).
  - The stalled access never reaches the PIC.
  - It passes through in the first IDLE cycle.
- Interrupt gating: cpu_interrupt_do = pic_interrupt_do & ~init_busy.
- init_busy is 1 in BOOT (AUTO_INIT=1), ISSUE and GAP.
- init_done pulses in the ISSUE cycle of step 9.
- Simultaneous events:
  - init_start while busy is ignored; no restart or extension.
  - A CPU access in the same IDLE cycle as init_start passes through; the sequence starts on the next cycle.
  - Reset mid-sequence aborts immediately. A fresh boot follows, always starting at step 0.
- Widths: step is 4 bits, values 0..9, never wraps. gap_cnt is 4 bits.

Decomposition:
- Shared package pic_pkg:
  - state enum {BOOT, IDLE, ISSUE, GAP}
  - ICW1_EDGE_ICW4 = 8'h11
  - ICW3_MASTER_CASCADE = 8'h04
  - ICW3_SLAVE_ID = 8'h02
  - ICW4_8086 = 8'h01
  - NUM_STEPS = 10
- Sub-module pic_init_rom: a combinational step → {addr, data, slave_sel} table, to keep the FSM generic.

Test Plan:
- Reset release, AUTO_INIT=1, WRITE_GAP=2:
  - Exactly 10 pic_write pulses, 3 cycles apart, with data 11,08,04,01,B8 (master) then 11,70,02,01,FF (slave).
  - init_done pulses with the 10th write, and init_busy falls on the next cycle.
- CPU write to 21h (data 8'hFC) asserted during step 3:
  - cpu_wait is held high and no CPU data appears on pic_writedata during the sequence.
  - The write reaches the PIC in the first IDLE cycle, and cpu_wait deasserts that cycle.
- pic_interrupt_do=1 throughout:
  - cpu_interrupt_do=0 while init_busy=1.
  - cpu_interrupt_do follows pic_interrupt_do from the first IDLE cycle.
- init_start pulsed at step 6:
  - Ignored; the sequence completes with exactly 10 writes.
  - A second init_start in IDLE produces 10 more writes.
- rst_n low during GAP after step 7:
  - All pic_write stop immediately.
  - After release, the sequence restarts at step 0 with data 8'h11 to the master.
- WRITE_GAP=0, AUTO_INIT=0:
  - No writes after reset.
  - init_start then yields 10 back-to-back write cycles.

Source files
------------

// File: rtl/pic_pkg.sv
// pic_pkg
//   Shared types and constants for the 8259 boot-time init arbiter.
//   - state_e : sequencer FSM states
//   - ICW/step constants used by the init ROM and the FSM
package pic_pkg;

  typedef enum logic [1:0] {BOOT, IDLE, ISSUE, GAP} state_e;

  localparam logic [7:0] ICW1_EDGE_ICW4      = 8'h11;  // edge-triggered, cascade, ICW4 needed
  localparam logic [7:0] ICW3_MASTER_CASCADE = 8'h04;  // slave hangs off IR2
  localparam logic [7:0] ICW3_SLAVE_ID       = 8'h02;  // slave cascade identity
  localparam logic [7:0] ICW4_8086           = 8'h01;  // 8086 mode, normal EOI

  localparam int         NUM_STEPS = 10;
  localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

endpackage

// File: rtl/pic_init_rom.sv
// pic_init_rom
//   Combinational step -> write table for the master/slave 8259 init sequence.
//   Steps 0-4 target the master, steps 5-9 the slave (ICW1..ICW4, OCW1).
//   Ports:
//     step      in  4  sequence index 0..9
//     addr      out 1  PIC A0 for this write
//     data      out 8  write data
//     slave_sel out 1  1 = slave chip select, 0 = master
module pic_init_rom
  import pic_pkg::*;
#(
  parameter logic [7:0] MASTER_BASE = 8'h08,
  parameter logic [7:0] SLAVE_BASE  = 8'h70,
  parameter logic [7:0] MASTER_MASK = 8'hB8,
  parameter logic [7:0] SLAVE_MASK  = 8'hFF
) (
  input  logic [3:0] step,
  output logic       addr,
  output logic [7:0] data,
  output logic       slave_sel
);

  always_comb begin
    addr      = 1'b1;
    data      = 8'h00;
    slave_sel = (step >= 4'd5);
    case (step)
      4'd0, 4'd5: begin
        addr = 1'b0;
        data = ICW1_EDGE_ICW4;
      end
      4'd1:       data = {MASTER_BASE[7:3], 3'b000};
      4'd6:       data = {SLAVE_BASE[7:3], 3'b000};
      4'd2:       data = ICW3_MASTER_CASCADE;
      4'd7:       data = ICW3_SLAVE_ID;
      4'd3, 4'd8: data = ICW4_8086;
      4'd4:       data = MASTER_MASK;
      4'd9:       data = SLAVE_MASK;
      default: begin
        addr      = 1'b0;
        slave_sel = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pic_init_arbiter.sv
// pic_init_arbiter
//   Boot-time configurator for the cascaded 8259 pair. Owns the PIC I/O port
//   while writing the fixed ICW1-ICW4/OCW1 sequence to both chips, stalling
//   CPU accesses and masking the interrupt request; passes the CPU through
//   when idle.
//   Ports:
//     clk, rst_n             clock, async active-low reset
//     init_start             re-run request (ignored while busy)
//     init_busy, init_done   sequencing status / last-write pulse
//     cpu_*                  CPU side of the PIC port; cpu_wait stalls it
//     pic_*                  PIC side of the port
//     pic_interrupt_do       raw PIC interrupt request
//     cpu_interrupt_do       request gated off while sequencing
module pic_init_arbiter
  import pic_pkg::*;
#(
  parameter logic [7:0] MASTER_BASE = 8'h08,
  parameter logic [7:0] SLAVE_BASE  = 8'h70,
  parameter logic [7:0] MASTER_MASK = 8'hB8,
  parameter logic [7:0] SLAVE_MASK  = 8'hFF,
  parameter int         WRITE_GAP   = 2,
  parameter int         AUTO_INIT   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_start,
  output logic       init_busy,
  output logic       init_done,
  input  logic       cpu_address,
  input  logic       cpu_read,
  input  logic       cpu_write,
  input  logic [7:0] cpu_writedata,
  input  logic       cpu_master_cs,
  input  logic       cpu_slave_cs,
  output logic       cpu_wait,
  output logic       pic_address,
  output logic       pic_read,
  output logic       pic_write,
  output logic [7:0] pic_writedata,
  output logic       pic_master_cs,
  output logic       pic_slave_cs,
  input  logic       pic_interrupt_do,
  output logic       cpu_interrupt_do
);

  localparam bit         AUTO     = (AUTO_INIT != 0);
  localparam bit         NO_GAP   = (WRITE_GAP == 0);
  localparam logic [3:0] GAP_LOAD = 4'(WRITE_GAP - 1);

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  // BOOT is entered while reset is held; armed_q marks the single BOOT cycle
  // after release so outputs stay in pass-through (busy=0) during reset.
  logic       armed_q, armed_d;

  logic       rom_addr, rom_slave;
  logic [7:0] rom_data;

  pic_init_rom #(
    .MASTER_BASE (MASTER_BASE),
    .SLAVE_BASE  (SLAVE_BASE),
    .MASTER_MASK (MASTER_MASK),
    .SLAVE_MASK  (SLAVE_MASK)
  ) u_rom (
    .step      (step_q),
    .addr      (rom_addr),
    .data      (rom_data),
    .slave_sel (rom_slave)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      step_q    <= 4'd0;
      gap_cnt_q <= 4'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      gap_cnt_q <= gap_cnt_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    gap_cnt_d = gap_cnt_q;
    armed_d   = 1'b1;
    case (state_q)
      BOOT: begin
        step_d = 4'd0;
        if (armed_q) state_d = AUTO ? ISSUE : IDLE;
      end
      IDLE: begin
        step_d = 4'd0;
        if (init_start) state_d = ISSUE;
      end
      ISSUE: begin
        if (step_q == LAST_STEP) begin
          state_d = IDLE;
          step_d  = 4'd0;
        end else if (NO_GAP) begin
          step_d = step_q + 4'd1;
        end else begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = ISSUE;
          step_d  = step_q + 4'd1;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    init_busy = (state_q == ISSUE) || (state_q == GAP) ||
                ((state_q == BOOT) && armed_q && AUTO);
    init_done = (state_q == ISSUE) && (step_q == LAST_STEP);

    // Default: CPU owns the port.
    pic_address   = cpu_address;
    pic_read      = cpu_read;
    pic_write     = cpu_write;
    pic_writedata = cpu_writedata;
    pic_master_cs = cpu_master_cs;
    pic_slave_cs  = cpu_slave_cs;
    cpu_wait      = 1'b0;

    if (init_busy) begin
      // Sequencer owns the port; a pending CPU access is held off entirely.
      pic_address   = 1'b0;
      pic_read      = 1'b0;
      pic_write     = 1'b0;
      pic_writedata = 8'h00;
      pic_master_cs = 1'b0;
      pic_slave_cs  = 1'b0;
      cpu_wait      = (cpu_read | cpu_write) & (cpu_master_cs | cpu_slave_cs);
      if (state_q == ISSUE) begin
        pic_address   = rom_addr;
        pic_write     = 1'b1;
        pic_writedata = rom_data;
        pic_master_cs = ~rom_slave;
        pic_slave_cs  = rom_slave;
      end
    end

    cpu_interrupt_do = pic_interrupt_do & ~init_busy;
  end

endmodule

// File: tb/tb_pic_init_arbiter.sv
module tb_pic_init_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters (AUTO_INIT=1, WRITE_GAP=2)
  logic       rst_n, init_start, init_busy, init_done;
  logic       cpu_address, cpu_read, cpu_write, cpu_master_cs, cpu_slave_cs, cpu_wait;
  logic [7:0] cpu_writedata, pic_writedata;
  logic       pic_address, pic_read, pic_write, pic_master_cs, pic_slave_cs;
  logic       pic_interrupt_do, cpu_interrupt_do;

  // DUT B: AUTO_INIT=0, WRITE_GAP=0
  logic       b_rst_n, b_init_start, b_init_busy, b_init_done;
  logic       b_cpu_wait, b_pic_address, b_pic_read, b_pic_write, b_pic_master_cs, b_pic_slave_cs;
  logic [7:0] b_pic_writedata;
  logic       b_cpu_interrupt_do;

  pic_init_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_master_cs(cpu_master_cs),
    .cpu_slave_cs(cpu_slave_cs), .cpu_wait(cpu_wait),
    .pic_address(pic_address), .pic_read(pic_read), .pic_write(pic_write),
    .pic_writedata(pic_writedata), .pic_master_cs(pic_master_cs),
    .pic_slave_cs(pic_slave_cs), .pic_interrupt_do(pic_interrupt_do),
    .cpu_interrupt_do(cpu_interrupt_do)
  );

  pic_init_arbiter #(.WRITE_GAP(0), .AUTO_INIT(0)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n), .init_start(b_init_start),
    .init_busy(b_init_busy), .init_done(b_init_done),
    .cpu_address(1'b0), .cpu_read(1'b0), .cpu_write(1'b0),
    .cpu_writedata(8'h00), .cpu_master_cs(1'b0),
    .cpu_slave_cs(1'b0), .cpu_wait(b_cpu_wait),
    .pic_address(b_pic_address), .pic_read(b_pic_read), .pic_write(b_pic_write),
    .pic_writedata(b_pic_writedata), .pic_master_cs(b_pic_master_cs),
    .pic_slave_cs(b_pic_slave_cs), .pic_interrupt_do(1'b1),
    .cpu_interrupt_do(b_cpu_interrupt_do)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Hand-computed write sequence for the default parameters.
  logic [7:0] exp_data  [10] = '{8'h11, 8'h08, 8'h04, 8'h01, 8'hB8,
                                 8'h11, 8'h70, 8'h02, 8'h01, 8'hFF};
  logic       exp_addr  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic       exp_slave [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  // Write log filled by run_seq / test_gap0.
  logic [7:0] wr_data  [32];
  logic       wr_addr  [32];
  logic       wr_slave [32];
  int         wr_cyc   [32];
  int         n_wr, done_cyc, done_cnt, fall_cyc, leak, wait_lo, fc_seen, bad_own;
  bit         timeout;
  logic       idle_write, idle_wait, idle_int, idle_mcs, idle_addr;
  logic [7:0] idle_data;

  function automatic int seq_errs();
    int e = 0;
    for (int i = 0; i < 10; i++)
      if (wr_data[i] !== exp_data[i] || wr_addr[i] !== exp_addr[i] ||
          wr_slave[i] !== exp_slave[i]) e++;
    return e;
  endfunction

  function automatic int spacing_errs(input int gap);
    int e = 0;
    for (int i = 1; i < 10; i++)
      if (wr_cyc[i] - wr_cyc[i-1] != gap) e++;
    return e;
  endfunction

  // Runs DUT A until init_busy falls (first IDLE cycle), logging writes.
  // stall_step: after that step's write, hold a CPU write to 21h (data FC).
  // restart_step: after that step's write, pulse init_start for one cycle.
  task automatic run_seq(input int stall_step, input int restart_step, input int budget);
    bit seen_busy = 0;
    bit stall_on = 0;
    bit restarted = 0;
    n_wr = 0; done_cyc = -1; done_cnt = 0; fall_cyc = -1;
    leak = 0; wait_lo = 0; fc_seen = 0; bad_own = 0; timeout = 1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (init_busy && pic_write) begin
        if (n_wr < 32) begin
          wr_data[n_wr]  = pic_writedata;
          wr_addr[n_wr]  = pic_address;
          wr_slave[n_wr] = pic_slave_cs;
          wr_cyc[n_wr]   = c;
        end
        if (pic_master_cs == pic_slave_cs) bad_own++;
        n_wr++;
      end
      if (init_busy && !pic_write && (pic_master_cs || pic_slave_cs)) bad_own++;
      if (init_busy && pic_read) bad_own++;
      if (init_done) begin done_cyc = c; done_cnt++; end
      if (init_busy && cpu_interrupt_do) leak++;
      if (init_busy && cpu_write && !cpu_wait) wait_lo++;
      if (init_busy && pic_writedata == 8'hFC) fc_seen++;
      if (seen_busy && !init_busy) begin
        fall_cyc   = c;
        idle_write = pic_write;
        idle_data  = pic_writedata;
        idle_wait  = cpu_wait;
        idle_int   = cpu_interrupt_do;
        idle_mcs   = pic_master_cs;
        idle_addr  = pic_address;
        timeout    = 0;
        init_start = 1'b0;
        break;
      end
      if (init_busy) seen_busy = 1;
      if (stall_step >= 0 && !stall_on && n_wr == stall_step + 1) begin
        cpu_write     = 1'b1;
        cpu_master_cs = 1'b1;
        cpu_address   = 1'b1;
        cpu_writedata = 8'hFC;
        stall_on      = 1;
      end
      if (restart_step >= 0 && !restarted && n_wr == restart_step + 1) begin
        init_start = 1'b1;
        restarted  = 1;
      end else begin
        init_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; b_rst_n = 1'b0;
    init_start = 1'b0; b_init_start = 1'b0;
    pic_interrupt_do = 1'b1;
    cpu_address = 1'b1; cpu_read = 1'b0; cpu_write = 1'b1;
    cpu_writedata = 8'hAA; cpu_master_cs = 1'b1; cpu_slave_cs = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (init_busy !== 1'b0) $display("FAIL rst_busy got %b want 0", init_busy); else pass_cnt++;
    total_cnt++; if (init_done !== 1'b0) $display("FAIL rst_done got %b want 0", init_done); else pass_cnt++;
    total_cnt++; if (cpu_wait !== 1'b0) $display("FAIL rst_wait got %b want 0", cpu_wait); else pass_cnt++;
    total_cnt++;
    if (pic_write !== 1'b1 || pic_writedata !== 8'hAA || pic_master_cs !== 1'b1 || pic_address !== 1'b1)
      $display("FAIL rst_passthru got wr=%b d=%h cs=%b a=%b want 1 AA 1 1",
               pic_write, pic_writedata, pic_master_cs, pic_address);
    else pass_cnt++;
    cpu_write = 1'b0; cpu_master_cs = 1'b0; cpu_address = 1'b0; cpu_writedata = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_auto_seq();
    rst_n = 1'b1;
    run_seq(-1, -1, 200);
    total_cnt++; if (timeout) $display("FAIL auto_timeout got busy never fell want fall"); else pass_cnt++;
    total_cnt++; if (n_wr !== 10) $display("FAIL auto_count got %0d want 10", n_wr); else pass_cnt++;
    total_cnt++; if (seq_errs() !== 0) $display("FAIL auto_data got %0d bad writes want 0", seq_errs()); else pass_cnt++;
    total_cnt++; if (spacing_errs(3) !== 0) $display("FAIL auto_spacing got %0d bad gaps want 0", spacing_errs(3)); else pass_cnt++;
    total_cnt++; if (done_cyc !== wr_cyc[9] || done_cnt !== 1)
      $display("FAIL auto_done got cyc=%0d n=%0d want cyc=%0d n=1", done_cyc, done_cnt, wr_cyc[9]); else pass_cnt++;
    total_cnt++; if (fall_cyc !== wr_cyc[9] + 1)
      $display("FAIL auto_busy_fall got %0d want %0d", fall_cyc, wr_cyc[9] + 1); else pass_cnt++;
    total_cnt++; if (bad_own !== 0) $display("FAIL auto_ownership got %0d bad cycles want 0", bad_own); else pass_cnt++;
    total_cnt++; if (leak !== 0) $display("FAIL irq_gated got %0d leaks want 0", leak); else pass_cnt++;
    total_cnt++; if (idle_int !== 1'b1) $display("FAIL irq_idle got %b want 1", idle_int); else pass_cnt++;
  endtask

  task automatic test_cpu_stall();
    @(negedge clk);
    init_start = 1'b1;
    run_seq(3, -1, 200);
    total_cnt++; if (n_wr !== 10) $display("FAIL stall_count got %0d want 10", n_wr); else pass_cnt++;
    total_cnt++; if (wait_lo !== 0) $display("FAIL stall_wait got %0d unstalled cycles want 0", wait_lo); else pass_cnt++;
    total_cnt++; if (fc_seen !== 0) $display("FAIL stall_leak got %0d cycles with FC want 0", fc_seen); else pass_cnt++;
    total_cnt++; if (seq_errs() !== 0) $display("FAIL stall_data got %0d bad writes want 0", seq_errs()); else pass_cnt++;
    total_cnt++;
    if (idle_write !== 1'b1 || idle_data !== 8'hFC || idle_mcs !== 1'b1 || idle_addr !== 1'b1 || idle_wait !== 1'b0)
      $display("FAIL stall_release got wr=%b d=%h cs=%b a=%b wait=%b want 1 FC 1 1 0",
               idle_write, idle_data, idle_mcs, idle_addr, idle_wait);
    else pass_cnt++;
    cpu_write = 1'b0; cpu_master_cs = 1'b0; cpu_address = 1'b0; cpu_writedata = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    init_start = 1'b1;
    run_seq(-1, 6, 200);
    total_cnt++; if (n_wr !== 10 || done_cnt !== 1)
      $display("FAIL busy_start got wr=%0d done=%0d want 10 1", n_wr, done_cnt); else pass_cnt++;
    total_cnt++; if (spacing_errs(3) !== 0) $display("FAIL busy_start_spacing got %0d want 0", spacing_errs(3)); else pass_cnt++;
    repeat (4) @(negedge clk);
    total_cnt++; if (init_busy !== 1'b0) $display("FAIL busy_start_idle got %b want 0", init_busy); else pass_cnt++;
    init_start = 1'b1;
    run_seq(-1, -1, 200);
    total_cnt++; if (n_wr !== 10) $display("FAIL second_start got %0d want 10", n_wr); else pass_cnt++;
    total_cnt++; if (seq_errs() !== 0) $display("FAIL second_start_data got %0d want 0", seq_errs()); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int n = 0;
    int stray = 0;
    bit reached = 0;
    init_start = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      init_start = 1'b0;
      if (init_busy && pic_write) n++;
      if (n == 8) begin reached = 1; break; end
    end
    total_cnt++; if (!reached) $display("FAIL abort_reach got %0d writes want 8", n); else pass_cnt++;
    @(negedge clk);   // now in GAP after step 7
    rst_n = 1'b0;
    #1;
    total_cnt++; if (pic_write !== 1'b0 || init_busy !== 1'b0)
      $display("FAIL abort_immediate got wr=%b busy=%b want 0 0", pic_write, init_busy); else pass_cnt++;
    repeat (3) begin
      @(negedge clk);
      if (pic_write) stray++;
    end
    total_cnt++; if (stray !== 0) $display("FAIL abort_stray got %0d want 0", stray); else pass_cnt++;
    rst_n = 1'b1;
    run_seq(-1, -1, 200);
    total_cnt++; if (wr_data[0] !== 8'h11 || wr_slave[0] !== 1'b0 || wr_addr[0] !== 1'b0)
      $display("FAIL abort_restart got d=%h slv=%b a=%b want 11 0 0", wr_data[0], wr_slave[0], wr_addr[0]); else pass_cnt++;
    total_cnt++; if (n_wr !== 10 || seq_errs() !== 0)
      $display("FAIL abort_full got wr=%0d errs=%0d want 10 0", n_wr, seq_errs()); else pass_cnt++;
  endtask

  task automatic test_gap0();
    int stray = 0;
    int busy_seen = 0;
    bit fell = 0;
    b_rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (b_pic_write) stray++;
      if (b_init_busy) busy_seen++;
    end
    total_cnt++; if (stray !== 0 || busy_seen !== 0)
      $display("FAIL gap0_noauto got wr=%0d busy=%0d want 0 0", stray, busy_seen); else pass_cnt++;
    b_init_start = 1'b1;
    n_wr = 0; done_cyc = -1; fall_cyc = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      b_init_start = 1'b0;
      if (b_init_busy && b_pic_write) begin
        if (n_wr < 32) begin
          wr_data[n_wr]  = b_pic_writedata;
          wr_addr[n_wr]  = b_pic_address;
          wr_slave[n_wr] = b_pic_slave_cs;
          wr_cyc[n_wr]   = c;
        end
        n_wr++;
      end
      if (b_init_done) done_cyc = c;
      if (n_wr > 0 && !b_init_busy) begin fall_cyc = c; fell = 1; break; end
    end
    total_cnt++; if (!fell) $display("FAIL gap0_timeout got no busy fall want fall"); else pass_cnt++;
    total_cnt++; if (n_wr !== 10) $display("FAIL gap0_count got %0d want 10", n_wr); else pass_cnt++;
    total_cnt++; if (spacing_errs(1) !== 0) $display("FAIL gap0_b2b got %0d gaps want 0", spacing_errs(1)); else pass_cnt++;
    total_cnt++; if (seq_errs() !== 0) $display("FAIL gap0_data got %0d bad writes want 0", seq_errs()); else pass_cnt++;
    total_cnt++; if (done_cyc !== wr_cyc[9] || fall_cyc !== wr_cyc[9] + 1)
      $display("FAIL gap0_done got done=%0d fall=%0d want %0d %0d", done_cyc, fall_cyc, wr_cyc[9], wr_cyc[9] + 1);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_auto_seq();
    test_cpu_stall();
    test_start_ignored();
    test_reset_abort();
    test_gap0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
